// File: rtl/max7219_frame_tx_if.sv
// Frame-request and MAX7219 pin bundle for max7219_frame_tx.
// The master side is the upstream frame source. The slave side is the transmitter,
// which also drives the three serial pins.
interface max7219_frame_tx_if;
    logic         start;
    logic [127:0] pixels;
    logic [3:0]   intensity;
    logic         busy;
    logic         done;
    logic         max_din;
    logic         max_clk;
    logic         max_cs;

    modport master (
        output start, pixels, intensity,
        input  busy, done, max_din, max_clk, max_cs
    );

    modport slave (
        input  start, pixels, intensity,
        output busy, done, max_din, max_clk, max_cs
    );
endinterface

// File: rtl/max7219_frame_tx.sv
// Serialises a captured 128-bit frame to two cascaded MAX7219 drivers over DIN/CLK/LOAD.
// Each transaction is one 32-bit shift: the far-device word first, then the near-device word.
// The first frame after reset is prefixed with the driver configuration writes.
module max7219_frame_tx #(
    parameter int unsigned CLK_DIV = 4
) (
    input logic               clk,
    input logic               rst,
    max7219_frame_tx_if.slave bus
);

    localparam int unsigned    PhW          = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PhW-1:0] PhLast       = PhW'(CLK_DIV - 1);
    localparam logic [3:0]     TxnFirst     = 4'd0;
    localparam logic [3:0]     TxnIntensity = 4'd4;
    localparam logic [3:0]     TxnLast      = 4'd12;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StHigh,
        StLow,
        StLatch
    } state_e;

    state_e         state_q, state_d;
    logic [PhW-1:0] phase_q, phase_d;
    logic [4:0]     bit_q, bit_d;
    logic [3:0]     txn_q, txn_d;
    logic [31:0]    shreg_q, shreg_d;
    logic [127:0]   pix_q, pix_d;
    logic [3:0]     int_q, int_d;
    logic           init_done_q, init_done_d;
    logic           done_q, done_d;
    logic           max_clk_q, max_cs_q;
    logic           phase_end;

    // Transaction index -> 32-bit word.
    // Indices 0..3 are configuration, 4 is intensity, and 5..12 are rows 0..7.
    function automatic logic [31:0] txn_word(input logic [3:0]   idx,
                                             input logic [127:0] pix,
                                             input logic [3:0]   inten);
        logic [3:0]  addr;
        logic [7:0]  far_d;
        logic [7:0]  near_d;
        logic [2:0]  row;
        logic [63:0] mat_a;
        logic [63:0] mat_b;
        mat_a  = pix[127:64];
        mat_b  = pix[63:0];
        row    = 3'(idx - 4'd5);
        addr   = 4'h0;
        far_d  = 8'h00;
        near_d = 8'h00;
        case (idx)
            4'd0: addr = 4'h9;
            4'd1: begin addr = 4'hB; far_d = 8'h07; near_d = 8'h07; end
            4'd2: begin addr = 4'hC; far_d = 8'h01; near_d = 8'h01; end
            4'd3: addr = 4'hF;
            4'd4: begin addr = 4'hA; far_d = {4'h0, inten}; near_d = {4'h0, inten}; end
            default: begin
                // Row r sits in the top byte for r=0, so it is indexed from the MSB end.
                addr   = idx - 4'd4;
                far_d  = mat_a[{3'(3'd7 - row), 3'b000} +: 8];
                near_d = mat_b[{3'(3'd7 - row), 3'b000} +: 8];
            end
        endcase
        return {4'h0, addr, far_d, 4'h0, addr, near_d};
    endfunction

    assign phase_end = (phase_q == PhLast);

    // Next-state logic: phase timing, bit/transaction sequencing and frame capture.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        txn_d       = txn_q;
        shreg_d     = shreg_q;
        pix_d       = pix_q;
        int_d       = int_q;
        init_done_d = init_done_q;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A start landing in the done cycle is deliberately dropped.
                if (bus.start && !done_q) begin
                    pix_d   = bus.pixels;
                    int_d   = bus.intensity;
                    txn_d   = init_done_q ? TxnIntensity : TxnFirst;
                    shreg_d = txn_word(txn_d, pix_d, int_d);
                    phase_d = '0;
                    bit_d   = 5'd31;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (phase_end) begin
                    phase_d = '0;
                    state_d = StHigh;
                end else begin
                    phase_d = phase_q + PhW'(1);
                end
            end
            StHigh: begin
                if (phase_end) begin
                    phase_d = '0;
                    state_d = StLow;
                    // After bit 0 the line keeps bit 0 instead of shifting in a zero.
                    if (bit_q != 5'd0) begin
                        shreg_d = {shreg_q[30:0], 1'b0};
                    end
                end else begin
                    phase_d = phase_q + PhW'(1);
                end
            end
            StLow: begin
                if (phase_end) begin
                    phase_d = '0;
                    if (bit_q == 5'd0) begin
                        state_d = StLatch;
                    end else begin
                        bit_d   = bit_q - 5'd1;
                        state_d = StHigh;
                    end
                end else begin
                    phase_d = phase_q + PhW'(1);
                end
            end
            StLatch: begin
                if (phase_end) begin
                    phase_d = '0;
                    if (txn_q == TxnLast) begin
                        state_d     = StIdle;
                        done_d      = 1'b1;
                        init_done_d = 1'b1;
                        shreg_d     = '0;
                    end else begin
                        txn_d   = txn_q + 4'd1;
                        shreg_d = txn_word(txn_d, pix_q, int_q);
                        bit_d   = 5'd31;
                        state_d = StSetup;
                    end
                end else begin
                    phase_d = phase_q + PhW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset drops LOAD high at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            phase_q     <= '0;
            bit_q       <= '0;
            txn_q       <= '0;
            shreg_q     <= '0;
            pix_q       <= '0;
            int_q       <= '0;
            init_done_q <= 1'b0;
            done_q      <= 1'b0;
            max_clk_q   <= 1'b0;
            max_cs_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            txn_q       <= txn_d;
            shreg_q     <= shreg_d;
            pix_q       <= pix_d;
            int_q       <= int_d;
            init_done_q <= init_done_d;
            done_q      <= done_d;
            // Pins are registered from the next state so they stay glitch-free.
            max_clk_q   <= (state_d == StHigh);
            max_cs_q    <= (state_d == StIdle) || (state_d == StLatch);
        end
    end

    assign bus.busy    = (state_q != StIdle);
    assign bus.done    = done_q;
    assign bus.max_din = shreg_q[31];
    assign bus.max_clk = max_clk_q;
    assign bus.max_cs  = max_cs_q;

endmodule

// File: tb/tb_max7219_frame_tx.sv
// Scoreboard bench for max7219_frame_tx.
// Stimulus queues the expected SPI words and done latencies. A negedge monitor
// decodes the serial pins and checks them against those queues.
module tb_max7219_frame_tx;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    max7219_frame_tx_if bus ();
    max7219_frame_tx_if bus1 ();

    max7219_frame_tx #(.CLK_DIV(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    max7219_frame_tx #(.CLK_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int start_cyc;
    int done_cnt = 0;
    int din_err  = 0;

    logic [31:0] exp_q[$];
    int          lat_q[$];

    localparam logic [127:0] P1 = 128'hAA01020304050607_5510203040506070;
    localparam logic [127:0] P2 = 128'hFFFFFFFFFFFFFFFF_0000000000000000;
    localparam logic [127:0] P3 = 128'h1122334455667788_99AABBCCDDEEFF00;

    logic [31:0] f1[13] = '{32'h0900_0900, 32'h0B07_0B07, 32'h0C01_0C01, 32'h0F00_0F00,
                            32'h0A05_0A05, 32'h01AA_0155, 32'h0201_0210, 32'h0302_0320,
                            32'h0403_0430, 32'h0504_0540, 32'h0605_0650, 32'h0706_0760,
                            32'h0807_0870};
    logic [31:0] f2[9]  = '{32'h0A05_0A05, 32'h01FF_0100, 32'h02FF_0200, 32'h03FF_0300,
                            32'h04FF_0400, 32'h05FF_0500, 32'h06FF_0600, 32'h07FF_0700,
                            32'h08FF_0800};
    logic [31:0] f3[9]  = '{32'h0A03_0A03, 32'h0111_0199, 32'h0222_02AA, 32'h0333_03BB,
                            32'h0444_04CC, 32'h0555_05DD, 32'h0666_06EE, 32'h0777_07FF,
                            32'h0888_0800};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor for the CLK_DIV=4 instance: word decode, done latency, and DIN stability.
    logic [31:0] sh;
    logic [31:0] exp_w;
    int          nb;
    logic        pclk, pcs, pdin;
    always @(negedge clk) begin
        if (rst) begin
            nb   = 0;
            pclk = 1'b0;
            pcs  = 1'b1;
            pdin = 1'b0;
        end else begin
            if (bus.max_clk && !pclk && !bus.max_cs) begin
                if (bus.max_din !== pdin) din_err++;
                sh = {sh[30:0], bus.max_din};
                nb++;
            end else if (bus.max_clk && pclk && bus.max_din !== pdin) begin
                din_err++;
            end
            if (bus.max_cs && !pcs) begin
                check("word_bits", nb, 32);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL word_extra: got %h, expected no word", sh);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("word", sh, exp_w);
                end
                nb = 0;
            end
            if (bus.done) begin
                done_cnt++;
                check("busy_low_at_done", bus.busy, 0);
                if (lat_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL done_extra: got done at cycle %0d, expected none", cyc);
                end else begin
                    check("done_latency", cyc - start_cyc, lat_q.pop_front());
                end
            end
            pclk = bus.max_clk;
            pcs  = bus.max_cs;
            pdin = bus.max_din;
        end
    end

    // Monitor for the CLK_DIV=1 instance: phase lengths, LOAD width, and word capture.
    logic [31:0] sh1;
    logic [31:0] w1[$];
    int          hi_run, lo_run, cs_run, bad1;
    logic        p1clk, p1cs, p1din;
    always @(negedge clk) begin
        if (rst) begin
            hi_run = 0;
            lo_run = 0;
            cs_run = 0;
            p1clk  = 1'b0;
            p1cs   = 1'b1;
            p1din  = 1'b0;
        end else begin
            if (bus1.max_clk && bus1.max_cs) bad1++;
            if (!bus1.max_cs) cs_run++;
            if (bus1.max_cs && !p1cs) begin
                if (cs_run != 65) bad1++;
                if (lo_run != 1) bad1++;
                cs_run = 0;
                lo_run = 0;
                w1.push_back(sh1);
            end
            if (bus1.max_clk) begin
                if (!p1clk) begin
                    if (lo_run != 1) bad1++;
                    if (bus1.max_din !== p1din) bad1++;
                    lo_run = 0;
                    sh1 = {sh1[30:0], bus1.max_din};
                end
                hi_run++;
            end else begin
                if (p1clk) begin
                    if (hi_run != 1) bad1++;
                    hi_run = 0;
                end
                if (!bus1.max_cs) lo_run++;
            end
            p1clk = bus1.max_clk;
            p1cs  = bus1.max_cs;
            p1din = bus1.max_din;
        end
    end

    task automatic go();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        start_cyc = cyc;
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1);
    endtask

    task automatic wait_done(input int limit, input string name);
        int n = 0;
        while (!bus.done && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got no done within %0d cycles, expected done", name, limit);
        end
    endtask

    initial begin
        int d0;
        int s1;
        int n;
        bad1 = 0;
        rst  = 1'b1;
        bus.start = 1'b0;  bus.pixels = '0;  bus.intensity = '0;
        bus1.start = 1'b0; bus1.pixels = '0; bus1.intensity = '0;
        repeat (3) @(negedge clk);
        check("rst_cs", bus.max_cs, 1);
        check("rst_clk", bus.max_clk, 0);
        check("rst_din", bus.max_din, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.max_clk || bus1.max_clk) n++;
        end
        check("idle_no_sclk", n, 0);

        // First frame: configuration plus intensity plus rows.
        bus.pixels = P1;
        bus.intensity = 4'd5;
        foreach (f1[i]) exp_q.push_back(f1[i]);
        lat_q.push_back(3432);
        go();
        wait_done(4000, "frame1_done");
        // A start in the done cycle must be ignored.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        check("start_at_done_ignored", bus.busy, 0);
        check("frame1_words_left", exp_q.size(), 0);

        // Second frame: no configuration writes.
        bus.pixels = P2;
        foreach (f2[i]) exp_q.push_back(f2[i]);
        lat_q.push_back(2376);
        go();
        wait_done(3000, "frame2_done");
        repeat (5) @(negedge clk);
        check("frame2_words_left", exp_q.size(), 0);

        // Inputs change and start pulses mid-frame: the frame is unaffected.
        d0 = done_cnt;
        bus.pixels = P3;
        bus.intensity = 4'd3;
        foreach (f3[i]) exp_q.push_back(f3[i]);
        lat_q.push_back(2376);
        go();
        repeat (500) @(negedge clk);
        bus.pixels = ~P3;
        bus.intensity = 4'hF;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(3000, "frame3_done");
        repeat (3000) @(negedge clk);
        check("frame3_one_done", done_cnt - d0, 1);
        check("frame3_no_restart", bus.busy, 0);
        check("frame3_words_left", exp_q.size(), 0);

        // CLK_DIV=1 waveform timing on the second instance.
        @(negedge clk);
        bus1.start = 1'b1;
        @(negedge clk);
        s1 = cyc;
        bus1.start = 1'b0;
        n = 0;
        while (!bus1.done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("div1_latency", cyc - s1, 13 * 66);
        repeat (3) @(negedge clk);
        check("div1_words", w1.size(), 13);
        check("div1_word0", w1[0], 32'h0900_0900);
        check("div1_word4", w1[4], 32'h0A00_0A00);
        check("div1_word12", w1[12], 32'h0800_0800);
        check("div1_timing_errs", bad1, 0);

        // Reset during row 3: LOAD rises immediately, and the next frame re-sends the configuration.
        bus.pixels = P3;
        bus.intensity = 4'd3;
        foreach (f3[i]) exp_q.push_back(f3[i]);
        lat_q.push_back(2376);
        go();
        repeat (1150) @(negedge clk);
        check("words_before_reset", exp_q.size(), 5);
        check("busy_before_reset", bus.busy, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_cs", bus.max_cs, 1);
        check("midrst_busy", bus.busy, 0);
        exp_q.delete();
        lat_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        bus.pixels = P1;
        bus.intensity = 4'd5;
        foreach (f1[i]) exp_q.push_back(f1[i]);
        lat_q.push_back(3432);
        go();
        wait_done(4000, "frame_after_reset_done");
        repeat (5) @(negedge clk);
        check("after_reset_words_left", exp_q.size(), 0);
        check("din_stable", din_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/max7219_frame_tx.md
# max7219_frame_tx

Frame transmitter for two cascaded MAX7219 8x8 LED drivers. Captures the 128-bit pixel frame held by the column-shift stage and serialises it over the MAX7219 3-wire interface (DIN/CLK/LOAD) as one row-register write per row. The first frame after reset is preceded by the driver configuration writes. Sits directly downstream of the pixel shift buffer and drives the board pins.

## Interface
- `CLK_DIV`, default 4: half-period of `max_clk`, in `clk` cycles; legal range 1 or more.
- `clk` input 1: system clock; all logic on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle request to send a frame; ignored while `busy`.
- `pixels` input 128: frame. `[127:64]` is matrix A (far device); `[63:0]` is matrix B (near device). Row r (0..7) of A is `pixels[127-8r -: 8]`, and of B is `pixels[63-8r -: 8]`.
- `intensity` input 4: brightness for register 0x0A.
- `busy` output 1: high while a frame is in progress.
- `done` output 1: one-cycle pulse when a frame completes.
- `max_din` output 1: serial data, MSB first.
- `max_clk` output 1: serial clock; the device samples on the rising edge.
- `max_cs` output 1: LOAD; low during a transaction, and its rising edge latches the data.

## Operation
- On `start` while idle, `pixels` and `intensity` are captured into internal registers. Later changes to either input do not affect the frame in progress.
- Each transaction is 32 bits: the far-device word followed by the near-device word.
  - Word format: `{4'h0, addr[3:0], data[7:0]}`.
- Transaction sequence per frame:
  - First frame after reset only (`init_done` = 0): 0x09/0x00 (no decode), 0x0B/0x07 (scan limit), 0x0C/0x01 (normal operation), 0x0F/0x00 (test off), each sent to both devices. `init_done` is set at the end of that frame.
  - Every frame: 0x0A/{4'h0,intensity} to both devices.
  - Every frame: rows r = 0..7, addr = r+1. The far word carries A row r; the near word carries B row r.
  - Result: 13 transactions for the first frame, 9 for later frames.
- FSM states:
  - IDLE: on `start`, go to SETUP.
  - SETUP: `max_cs`=0, `max_clk`=0, `max_din` = bit 31; lasts CLK_DIV cycles, then go to HIGH.
  - HIGH: `max_clk`=1; lasts CLK_DIV cycles, then go to LOW.
  - LOW: `max_clk`=0; `max_din` = next bit. After 32 HIGH phases, go to LATCH; otherwise go to HIGH.
  - LATCH: `max_cs`=1, `max_clk`=0; lasts CLK_DIV cycles. Then go to SETUP for the next transaction, or to IDLE with `done` if this was the last.
- Counters:
  - Phase counter: 0..CLK_DIV-1.
  - Bit counter: 0..31.
  - Transaction index: 0..12. Initialisation entries are skipped when `init_done` = 1.
- `max_din` only changes while `max_clk` is low, and is held through each high phase. In the LOW phase after bit 0, `max_din` holds bit 0.

## Timing
- Reset values (applied asynchronously): `busy`=0, `done`=0, `max_cs`=1, `max_clk`=0, `max_din`=0, `init_done`=0, FSM = IDLE.
- `start` sampled at edge k: `busy`=1 and SETUP begin after edge k.
- Transaction length: CLK_DIV + 64·CLK_DIV + CLK_DIV = 66·CLK_DIV cycles.
- Frame length (`busy` high): 13·66·CLK_DIV cycles for the first frame, 9·66·CLK_DIV for later frames. With CLK_DIV=4 this is 3432 and 2376 cycles.
- `done` is high for exactly the one cycle after the final LATCH phase. `busy` falls in the same cycle.
- `start` in the same cycle as `done` is ignored. A new frame requires `start` while `busy`=0.
- Reset mid-frame:
  - The frame is abandoned with no `done` pulse.
  - `max_cs` returns high immediately, so the partial word is latched by the device. The following full frame overwrites it.
  - `init_done` clears, so the next frame re-sends the configuration.

## Test plan
- Reset check: assert `rst` -> `max_cs`=1, `max_clk`=0, `max_din`=0, `busy`=0, `done`=0, with no `max_clk` edges for 100 cycles.
- First frame: CLK_DIV=4, `intensity`=5, `pixels[127:120]`=0xAA, `pixels[63:56]`=0x55, `start` -> the SPI monitor decodes 13 words in order: 0x0900_0900, 0x0B07_0B07, 0x0C01_0C01, 0x0F00_0F00, 0x0A05_0A05, 0x01AA_0155, … ; `done` pulses 3432 cycles after `start`.
- Second frame: `pixels` = 0xFF in every row of A and 0x00 in every row of B, `start` -> 9 words: 0x0A05_0A05, then 0x01FF_0100 … 0x08FF_0800; `done` after 2376 cycles.
- Capture and busy rules: change `pixels` and `intensity`, and pulse `start`, mid-frame -> the frame's words are unchanged, no extra frame follows, and exactly one `done`.
- Waveform timing: CLK_DIV=1 -> `max_clk` high for 1 cycle and low for 1 cycle; `max_din` stable across every rising edge; `max_cs` low for exactly 65 cycles per transaction.
- Reset mid-frame: assert `rst` during row 3 -> `max_cs`=1 in the same cycle; the next `start` yields 13 transactions beginning with 0x0900_0900.
